// File: rtl/lnl_host_loader_if.sv
// Host pin and memory bus bundle for lnl_host_loader.
// The loader side uses the slave modport; the host/bus model side uses master.
interface lnl_host_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [7:0]        host_data;
    logic              host_stb;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              busy;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  host_data, host_stb, mem_ack, mem_rdata,
        output out_byte, out_valid, busy, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output host_data, host_stb, mem_ack, mem_rdata,
        input  out_byte, out_valid, busy, err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lnl_host_loader.sv
// Byte-serial host port: assembles command/address/data bytes from an async
// strobe, runs one req/ack memory transaction and returns read data bytewise.
module lnl_host_loader #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    lnl_host_loader_if.slave   bus
);
    localparam int AB = (ADDR_W + 7) / 8;
    localparam int DB = (DATA_W + 7) / 8;
    localparam logic [1:0]  LAST_A = 2'(AB - 1);
    localparam logic [1:0]  LAST_D = 2'(DB - 1);
    localparam logic [15:0] LAST_T = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q, sync_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              req_q, req_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              stb;
    logic [7:0]        out_byte_c;

    // Two synchroniser stages, third stage only for rising-edge detection.
    assign sync_d = {sync_q[1:0], bus.host_stb};
    assign stb    = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            req_q   <= req_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        req_d   = req_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (stb) begin
                    idx_d = '0;
                    unique case (bus.host_data[7:6])
                        2'b10: begin
                            we_d    = 1'b1;
                            state_d = S_ADDR;
                        end
                        2'b01: begin
                            we_d    = 1'b0;
                            state_d = S_ADDR;
                        end
                        2'b11:   err_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            S_ADDR: begin
                if (stb) begin
                    // Little-endian: byte idx_q lands on bits [8*idx+7 : 8*idx], excess bits dropped.
                    for (int i = 0; i < ADDR_W; i++) begin
                        if (i[4:3] == idx_q) addr_d[i] = bus.host_data[i[2:0]];
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_A) begin
                        idx_d = '0;
                        if (we_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_BUS;
                            req_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (stb) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (i[4:3] == idx_q) wdata_d[i] = bus.host_data[i[2:0]];
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_D) begin
                        idx_d   = '0;
                        state_d = S_BUS;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            S_BUS: begin
                if (stb) err_d = 1'b1;
                if (bus.mem_ack) begin
                    req_d   = 1'b0;
                    rdata_d = bus.mem_rdata;
                    idx_d   = '0;
                    state_d = we_q ? S_IDLE : S_RESP;
                end else if (cnt_q == LAST_T) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (stb) begin
                    if (idx_q == LAST_D) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bits of the final response byte beyond DATA_W stay 0.
    always_comb begin
        out_byte_c = '0;
        if (state_q == S_RESP) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (i[4:3] == idx_q) out_byte_c[i[2:0]] = rdata_q[i];
            end
        end
    end

    assign bus.out_byte  = out_byte_c;
    assign bus.out_valid = (state_q == S_RESP);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err       = err_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: doc/lnl_host_loader.md
Name: lnl_host_loader

Overview:
Parametrised byte-serial host port for the LnL SoC. An external host, driving the chip's dedicated 8-bit input pins plus a strobe pin, uses it to read and write SoC memory. The block assembles command, address and data bytes, issues one transaction on the internal req/ack memory bus, and returns read data byte-serially on an 8-bit output. It generalises the fixed pin-level harness to configurable address and data widths, with bus timeout and error reporting.

Parameters:
ADDR_W, 12, memory address width in bits (1..32); AB = ceil(ADDR_W/8) address bytes.
DATA_W, 16, memory data width in bits (8..32); DB = ceil(DATA_W/8) data bytes.
TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting (1..65535).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
host_data  in  8  host byte; must be stable for at least 4 clk cycles after a host_stb rising edge.
host_stb  in  1  asynchronous host strobe; each rising edge delivers one byte or consumes one response byte.
out_byte  out  8  current response byte.
out_valid  out  1  out_byte holds valid read data.
busy  out  1  high in every state except IDLE.
err  out  1  sticky error flag.
mem_req  out  1  bus request.
mem_we  out  1  1 = write, 0 = read.
mem_addr  out  ADDR_W  bus address.
mem_wdata  out  DATA_W  write data.
mem_ack  in  1  bus acknowledge.
mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.

Behaviour:
- Reset (asynchronous, rst_n low) clears all outputs and internal registers to 0. State returns to IDLE.
- Strobe path: host_stb passes through a 2-flop synchroniser, then a third flop for edge detection.
  - A rising edge produces a single-cycle internal pulse "stb" 3 clk edges after the pin rises.
  - host_data is sampled on the stb cycle.
- Command byte (IDLE only), decoded from bits[7:6]:
  - 10 = write; go to ADDR.
  - 01 = read; go to ADDR.
  - 11 = clear; err <= 0, stay in IDLE.
  - 00 = no-op, ignored.
  - Bits[5:0] are ignored.
- ADDR: accepts AB bytes, little-endian; address bits above ADDR_W are discarded.
  - After the last byte: write goes to DATA; read goes to BUS.
- DATA: accepts DB bytes, little-endian; bits above DATA_W are discarded. After the last byte, go to BUS.
- BUS:
  - mem_req=1 with mem_we, mem_addr and mem_wdata held constant until the first cycle in which mem_ack=1.
  - mem_req drops the following cycle.
  - mem_rdata is captured in the ack cycle.
  - Write: return to IDLE. Read: go to RESP.
  - A cycle counter starts at 0 on entry to BUS. If it reaches TIMEOUT without an ack: mem_req <= 0, err <= 1, go to IDLE.
  - mem_ack while mem_req=0 is ignored.
- RESP:
  - out_valid=1 and out_byte = byte 0 of the captured word.
  - Each stb advances to the next byte.
  - The stb after the last byte (byte DB-1) clears out_valid and returns to IDLE.
  - Bits of the last byte above DATA_W read as 0.
- stb during BUS: ignored and sets err=1. The transaction still completes normally.
- err is set only by a timeout or by stb during BUS, and cleared only by a clear command or by reset.
- Minimum latency: the first mem_req rises 1 cycle after the stb of the final byte.
- Reset mid-transaction: mem_req drops immediately (asynchronously). No partial state survives.

Test Plan:
- Write, defaults: cmd 0x80, addr 0x34, 0xF2, data 0xCD, 0xAB; ack 2 cycles after req -> one mem_req pulse with mem_we=1, mem_addr=0x234, mem_wdata=0xABCD; busy falls the cycle after ack; err=0.
- Read: cmd 0x40, addr 0x10, 0x00; bus returns mem_rdata=0xBEEF -> out_valid=1 with out_byte=0xEF; next stb gives 0xBE; next stb clears out_valid and drops busy.
- Timeout, TIMEOUT=8: read to 0x001 with mem_ack held 0 -> mem_req falls after 8 cycles; err=1; busy=0. Cmd 0xC0 -> err=0.
- Strobe during BUS: ack delayed 20 cycles and a host strobe pulsed meanwhile -> err=1 and the write still completes with the correct address and data.
- Parameter sweep ADDR_W=8/DATA_W=8 and ADDR_W=20/DATA_W=32 -> 1+1+1 and 1+3+4 byte sequences respectively; addr/data bits beyond the width are ignored.
- Reset during the second address byte, then cmd 0x00 followed by a fresh write -> no bus activity from the aborted command; the fresh write is correct.
